reg_bus_arbiter: RTL and testbench



---
 rtl/reg_arb_pkg.sv | 12 +
 rtl/reg_arb_rr_pick.sv | 29 ++
 rtl/reg_bus_arbiter.sv | 120 ++++++++++++
 tb/tb_reg_bus_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the peripheral register-bus arbiter.
package reg_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam int          MAX_REQ       = 4;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping modulo NUM_REQ.
module reg_arb_rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    // The last granted requester (ptr) is visited last, giving strict rotation.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if ((k <= NUM_REQ) && !gnt_vld && req[idx[IDX_W-1:0]]) begin
                gnt_idx = idx[IDX_W-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus among NUM_REQ masters.
// Optional bus timeout is enabled by defining REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 9,
    parameter int TO_CYCLES = 255
) (
    input  logic                      app_clk,
    input  logic                      app_rst,
    input  logic [NUM_REQ-1:0]        m_cs,
    input  logic [NUM_REQ-1:0]        m_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
    input  logic [NUM_REQ*32-1:0]     m_wdata,
    input  logic [NUM_REQ*4-1:0]      m_be,
    output logic [31:0]               m_rdata,
    output logic [NUM_REQ-1:0]        m_ack,
    output logic [NUM_REQ-1:0]        m_err,
    output logic                      reg_cs,
    output logic                      reg_wr,
    output logic [ADDR_W-1:0]         reg_addr,
    output logic [31:0]               reg_wdata,
    output logic [3:0]                reg_be,
    input  logic [31:0]               reg_rdata,
    input  logic                      reg_ack
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    reg_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (m_cs),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

`ifdef REG_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == TO_W'(TO_CYCLES - 1));
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = TIMEOUT_RDATA ^ 32'(TO_CYCLES);
    assign m_err      = '0;
`endif

    // rr_ptr is loaded with the winner on grant, so it also names the owner while BUSY.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_be    <= '0;
            m_rdata   <= '0;
            m_ack     <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            m_err     <= '0;
            to_cnt    <= '0;
`endif
        end else begin
            m_ack <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            m_err <= '0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        rr_ptr    <= pick_idx;
                        reg_cs    <= 1'b1;
                        reg_wr    <= m_wr[pick_idx];
                        reg_addr  <= m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        reg_wdata <= m_wdata[int'(pick_idx)*32 +: 32];
                        reg_be    <= m_be[int'(pick_idx)*4 +: 4];
                        state     <= BUSY;
`ifdef REG_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (reg_ack) begin
                        reg_cs        <= 1'b0;
                        m_rdata       <= reg_rdata;
                        m_ack[rr_ptr] <= 1'b1;
                        state         <= IDLE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        reg_cs        <= 1'b0;
                        m_rdata       <= TIMEOUT_RDATA;
                        m_ack[rr_ptr] <= 1'b1;
                        m_err[rr_ptr] <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level round-robin model.
`timescale 1ns/1ps
module tb_reg_bus_arbiter;
    import reg_arb_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int ADDR_W    = 9;
    localparam int TO_CYCLES = 8;

    logic                      app_clk = 1'b0;
    logic                      app_rst;
    logic [NUM_REQ-1:0]        m_cs;
    logic [NUM_REQ-1:0]        m_wr;
    logic [NUM_REQ*ADDR_W-1:0] m_addr;
    logic [NUM_REQ*32-1:0]     m_wdata;
    logic [NUM_REQ*4-1:0]      m_be;
    logic [31:0]               m_rdata;
    logic [NUM_REQ-1:0]        m_ack;
    logic [NUM_REQ-1:0]        m_err;
    logic                      reg_cs;
    logic                      reg_wr;
    logic [ADDR_W-1:0]         reg_addr;
    logic [31:0]               reg_wdata;
    logic [3:0]                reg_be;
    logic [31:0]               reg_rdata;
    logic                      reg_ack;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 app_clk = ~app_clk;

    reg_bus_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .app_clk   (app_clk),
        .app_rst   (app_rst),
        .m_cs      (m_cs),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .m_err     (m_err),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    // Inputs change on the falling edge; outputs are inspected there too.
    task automatic tick();
        @(posedge app_clk);
        @(negedge app_clk);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        m_cs[i]                    = 1'b1;
        m_wr[i]                    = wr;
        m_addr[i*ADDR_W +: ADDR_W] = addr;
        m_wdata[i*32 +: 32]        = wdata;
        m_be[i*4 +: 4]             = be;
    endtask

    task automatic reset_dut();
        app_rst   = 1'b1;
        m_cs      = '0;
        m_wr      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        m_be      = '0;
        reg_ack   = 1'b0;
        reg_rdata = '0;
        tick();
        app_rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        app_rst = 1'b1;
        m_cs    = '1;
        tick();
        tick();
        tests_run++;
        if (reg_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_reg_cs: got %b, expected 0", reg_cs);
        end
        tests_run++;
        if ({m_ack, m_err, m_rdata, reg_addr} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ack=%b err=%b rdata=%h addr=%h, expected all 0",
                     m_ack, m_err, m_rdata, reg_addr);
        end
        m_cs    = '0;
        app_rst = 1'b0;
        tick();
        tests_run++;
        if (reg_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got reg_cs=%b, expected 0", reg_cs);
        end
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 9'h080, 32'h1234_5678, 4'hF);
        tick();
        tests_run++;
        if ({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be} !== {1'b1, 1'b1, 9'h080, 32'h1234_5678, 4'hF}) begin
            tests_failed++;
            $display("[TB] FAIL single_fields: got cs=%b wr=%b addr=%h wdata=%h be=%h, expected 1 1 080 12345678 f",
                     reg_cs, reg_wr, reg_addr, reg_wdata, reg_be);
        end
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (m_ack !== 2'b00 || reg_cs !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL single_wait: got ack=%b cs=%b, expected 00 1", m_ack, reg_cs);
            end
            tick();
        end
        reg_ack   = 1'b1;
        reg_rdata = 32'h0000_0000;
        tick();
        reg_ack = 1'b0;
        m_cs    = '0;
        tests_run++;
        if (m_ack !== 2'b01 || reg_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_ack: got ack=%b cs=%b, expected 01 0", m_ack, reg_cs);
        end
        tick();
        tests_run++;
        if (m_ack !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL single_ack_pulse: got ack=%b, expected 00", m_ack);
        end
    endtask

    task automatic test_alternate();
        logic [NUM_REQ-1:0] exp_ack;
        logic [ADDR_W-1:0]  exp_addr;
        int                 g;
        reset_dut();
        set_req(0, 1'b0, 9'h010, 32'h0, 4'hF);
        set_req(1, 1'b0, 9'h020, 32'h0, 4'hF);
        for (int n = 0; n < 4; n++) begin
            g        = n % 2;
            exp_ack  = NUM_REQ'(1) << g;
            exp_addr = (g == 0) ? 9'h010 : 9'h020;
            tick();
            tests_run++;
            if (reg_cs !== 1'b1 || reg_addr !== exp_addr || reg_wr !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL alt_grant%0d: got cs=%b addr=%h wr=%b, expected 1 %h 0",
                         n, reg_cs, reg_addr, reg_wr, exp_addr);
            end
            reg_ack   = 1'b1;
            reg_rdata = 32'hA0 + 32'(n);
            tick();
            reg_ack = 1'b0;
            tests_run++;
            if (m_ack !== exp_ack || m_rdata !== 32'hA0 + 32'(n) || reg_cs !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL alt_ack%0d: got ack=%b rdata=%h cs=%b, expected %b %h 0",
                         n, m_ack, m_rdata, reg_cs, exp_ack, 32'hA0 + 32'(n));
            end
        end
        m_cs = '0;
        tick();
        tests_run++;
        if (reg_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL alt_end: got cs=%b, expected 0", reg_cs);
        end
    endtask

    task automatic test_fast_ack();
        set_req(0, 1'b1, 9'h1F0, 32'hCAFE_0001, 4'h3);
        tick();
        tests_run++;
        if (reg_cs !== 1'b1 || reg_wdata !== 32'hCAFE_0001 || reg_be !== 4'h3) begin
            tests_failed++;
            $display("[TB] FAIL fast_grant: got cs=%b wdata=%h be=%h, expected 1 cafe0001 3",
                     reg_cs, reg_wdata, reg_be);
        end
        reg_ack   = 1'b1;
        reg_rdata = 32'h5555_AAAA;
        tick();
        reg_ack = 1'b0;
        m_cs    = '0;
        tests_run++;
        if (m_ack !== 2'b01 || reg_cs !== 1'b0 || m_rdata !== 32'h5555_AAAA) begin
            tests_failed++;
            $display("[TB] FAIL fast_ack: got ack=%b cs=%b rdata=%h, expected 01 0 5555aaaa",
                     m_ack, reg_cs, m_rdata);
        end
        tick();
        tests_run++;
        if (reg_cs !== 1'b0 || m_ack !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL fast_idle: got cs=%b ack=%b, expected 0 00", reg_cs, m_ack);
        end
    endtask

    task automatic test_drop_busy();
        set_req(1, 1'b0, 9'h0AB, 32'h0, 4'hF);
        tick();
        m_cs[1] = 1'b0;
        tests_run++;
        if (reg_cs !== 1'b1 || reg_addr !== 9'h0AB) begin
            tests_failed++;
            $display("[TB] FAIL drop_grant: got cs=%b addr=%h, expected 1 0ab", reg_cs, reg_addr);
        end
        tick();
        tests_run++;
        if (reg_cs !== 1'b1 || reg_addr !== 9'h0AB) begin
            tests_failed++;
            $display("[TB] FAIL drop_hold: got cs=%b addr=%h, expected 1 0ab", reg_cs, reg_addr);
        end
        reg_ack   = 1'b1;
        reg_rdata = 32'h1357_9BDF;
        tick();
        reg_ack = 1'b0;
        tests_run++;
        if (m_ack !== 2'b10 || m_rdata !== 32'h1357_9BDF) begin
            tests_failed++;
            $display("[TB] FAIL drop_ack: got ack=%b rdata=%h, expected 10 13579bdf", m_ack, m_rdata);
        end
        tick();
        tick();
        tests_run++;
        if (reg_cs !== 1'b0 || m_ack !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL drop_no_regrant: got cs=%b ack=%b, expected 0 00", reg_cs, m_ack);
        end
    endtask

    task automatic test_reset_busy();
        set_req(0, 1'b1, 9'h033, 32'hFFFF_0000, 4'hC);
        tick();
        tests_run++;
        if (reg_cs !== 1'b1 || reg_addr !== 9'h033) begin
            tests_failed++;
            $display("[TB] FAIL rstbusy_grant: got cs=%b addr=%h, expected 1 033", reg_cs, reg_addr);
        end
        app_rst   = 1'b1;
        reg_ack   = 1'b1;
        reg_rdata = 32'h7777_7777;
        tick();
        tests_run++;
        if ({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, m_ack, m_rdata, m_err} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rstbusy_outputs: got cs=%b wr=%b addr=%h wdata=%h be=%h ack=%b rdata=%h err=%b, expected all 0",
                     reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, m_ack, m_rdata, m_err);
        end
        app_rst = 1'b0;
        reg_ack = 1'b0;
        set_req(1, 1'b0, 9'h044, 32'h0, 4'hF);
        tick();
        tests_run++;
        if (reg_cs !== 1'b1 || reg_addr !== 9'h033) begin
            tests_failed++;
            $display("[TB] FAIL rstbusy_first: got cs=%b addr=%h, expected 1 033", reg_cs, reg_addr);
        end
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        m_cs    = '0;
        tests_run++;
        if (m_ack !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL rstbusy_ack: got ack=%b, expected 01", m_ack);
        end
        tick();
    endtask

`ifdef REG_ARB_TIMEOUT_EN
    task automatic test_timeout();
        reset_dut();
        set_req(0, 1'b0, 9'h100, 32'h0, 4'hF);
        tick();
        for (int b = 2; b <= TO_CYCLES; b++) begin
            tests_run++;
            if (reg_cs !== 1'b1 || m_ack !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL to_wait%0d: got cs=%b ack=%b, expected 1 00", b, reg_cs, m_ack);
            end
            tick();
        end
        tick();
        tests_run++;
        if (m_ack !== 2'b01 || m_err !== 2'b01 || m_rdata !== TIMEOUT_RDATA || reg_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL to_expire: got ack=%b err=%b rdata=%h cs=%b, expected 01 01 deadbeef 0",
                     m_ack, m_err, m_rdata, reg_cs);
        end
        m_cs      = '0;
        reg_ack   = 1'b1;
        reg_rdata = 32'h0000_1234;
        tick();
        reg_ack = 1'b0;
        tests_run++;
        if (m_ack !== 2'b00 || m_err !== 2'b00 || reg_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL to_late_ack: got ack=%b err=%b cs=%b, expected 00 00 0", m_ack, m_err, reg_cs);
        end
    endtask
`endif

    // Randomized requesters and slave; the model tracks only whether a transaction is open,
    // who owns it and who won last, and picks winners by the rotation rule.
    task automatic test_random(input int ncycles);
        logic               open;
        int                 owner;
        int                 last;
        int                 cand;
        logic               found;
        logic               exp_cs;
        logic [NUM_REQ-1:0] exp_ack;
        logic [31:0]        exp_rdata;
        logic               exp_wr;
        logic [ADDR_W-1:0]  exp_addr;
        logic [31:0]        exp_wdata;
        logic [3:0]         exp_be;
        int                 sl_wait;
        logic               prev_cs;
        reset_dut();
        open      = 1'b0;
        owner     = 0;
        last      = NUM_REQ - 1;
        exp_cs    = 1'b0;
        exp_ack   = '0;
        exp_rdata = '0;
        exp_wr    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_be    = '0;
        sl_wait   = 0;
        prev_cs   = 1'b0;
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            tests_run++;
            if (reg_cs !== exp_cs) begin
                tests_failed++;
                $display("[TB] FAIL rand_cs@%0d: got %b, expected %b", cyc, reg_cs, exp_cs);
            end
            if (exp_cs) begin
                tests_run++;
                if ({reg_wr, reg_addr, reg_wdata, reg_be} !== {exp_wr, exp_addr, exp_wdata, exp_be}) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_fields@%0d: got %b %h %h %h, expected %b %h %h %h", cyc,
                             reg_wr, reg_addr, reg_wdata, reg_be, exp_wr, exp_addr, exp_wdata, exp_be);
                end
            end
            tests_run++;
            if (m_ack !== exp_ack) begin
                tests_failed++;
                $display("[TB] FAIL rand_ack@%0d: got %b, expected %b", cyc, m_ack, exp_ack);
            end
            if (exp_ack != '0) begin
                tests_run++;
                if (m_rdata !== exp_rdata) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_rdata@%0d: got %h, expected %h", cyc, m_rdata, exp_rdata);
                end
            end
            tests_run++;
            if (m_err !== '0) begin
                tests_failed++;
                $display("[TB] FAIL rand_err@%0d: got %b, expected 0", cyc, m_err);
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_ack[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, 4'($urandom));
                    else
                        m_cs[i] = 1'b0;
                end else if (!m_cs[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, 4'($urandom));
                end
            end

            if (reg_cs && !prev_cs)
                sl_wait = $urandom_range(0, 3);
            prev_cs   = reg_cs;
            reg_rdata = $urandom;
            if (reg_cs) begin
                if (sl_wait == 0) begin
                    reg_ack = 1'b1;
                end else begin
                    reg_ack = 1'b0;
                    sl_wait--;
                end
            end else begin
                reg_ack = ($urandom_range(0, 5) == 0);
            end

            exp_ack = '0;
            if (!open) begin
                found = 1'b0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    cand = (last + k) % NUM_REQ;
                    if (!found && m_cs[cand]) begin
                        found = 1'b1;
                        owner = cand;
                    end
                end
                if (found) begin
                    last      = owner;
                    open      = 1'b1;
                    exp_cs    = 1'b1;
                    exp_wr    = m_wr[owner];
                    exp_addr  = m_addr[owner*ADDR_W +: ADDR_W];
                    exp_wdata = m_wdata[owner*32 +: 32];
                    exp_be    = m_be[owner*4 +: 4];
                end else begin
                    exp_cs = 1'b0;
                end
            end else if (reg_ack) begin
                exp_ack   = NUM_REQ'(1) << owner;
                exp_rdata = reg_rdata;
                open      = 1'b0;
                exp_cs    = 1'b0;
            end
            tick();
        end
        reg_ack = 1'b0;
        m_cs    = '0;
    endtask

    initial begin
        app_rst   = 1'b1;
        m_cs      = '0;
        m_wr      = '0;
        m_addr    = '0;
        m_wdata   = '0;
        m_be      = '0;
        reg_ack   = 1'b0;
        reg_rdata = '0;
        test_reset();
        test_single_write();
        test_alternate();
        test_fast_ack();
        test_drop_busy();
        test_reset_busy();
`ifdef REG_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
